// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// queue entry layout and small width helpers.
package ifu_pkg;

  // State encoding, also the value driven on the state output port
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_RUN   = 2'd1;
  localparam logic [1:0] STATE_FAULT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_RUN   = STATE_RUN,
    ST_FAULT = STATE_FAULT
  } ifu_state_e;

  // Queue entry layout, MSB first: {fault, pc[ADDR_W-1:0], instr[INSTR_W-1:0]}
  function automatic int entry_width(input int addr_w, input int instr_w);
    return instr_w + addr_w + 1;
  endfunction

  // Index width for an array of 'depth' words; never narrower than one bit
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Prefetch queue: small synchronous FIFO between the fetch stage and decode.
// Flush empties it and wins over a concurrent push. A push into a full queue
// is accepted only when a pop happens in the same cycle. The head reads as
// zero while the queue is empty so downstream sees clean data.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : slots[rd_ptr];

  // Pointer and occupancy bookkeeping; reset and flush both return to empty
  always_ff @(posedge Clk) begin
    if (!Reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Entry storage; contents are don't-care while not covered by count
  always_ff @(posedge Clk) begin
    if (Reset && !flush && do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, loadable instruction memory, fetch
// FSM and a prefetch queue that hands {instr, pc, pc+1, fault} to decode
// over a valid/ready handshake. Redirects flush the queue and reload the PC.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | after reset; no fetching, program load and redirect still accepted
//  RUN   | fetching one word per cycle whenever the queue has room
//  FAULT | an out-of-range fetch was queued; fetch halted until a redirect
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 8,
  parameter int MEM_DEPTH   = 8,
  parameter int QUEUE_DEPTH = 2,
  parameter int RESET_PC    = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_next,
  output logic               out_fault,
  output logic [1:0]         state
);

  localparam int ENTRY_W = entry_width(ADDR_W, INSTR_W);
  localparam int MIDX_W  = idx_width(MEM_DEPTH);
  // One extra bit so MEM_DEPTH == 2**ADDR_W is representable
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(RESET_PC);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];

  ifu_state_e         cur_state;
  ifu_state_e         nxt_state;
  logic [ADDR_W-1:0]  pc;
  logic               fetch_en;
  logic               fetch_fire;
  logic               pc_in_range;
  logic               prog_in_range;
  logic [INSTR_W-1:0] fetch_word;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] q_head;
  logic               q_full;
  logic               q_empty;
  logic               pop;

  assign pc_in_range   = ({1'b0, pc} < MEM_LIMIT);
  assign prog_in_range = ({1'b0, prog_addr} < MEM_LIMIT);

  // Handshake: the queue head is offered whenever the queue is non-empty
  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready;

  // A full queue can still take a new entry when the head leaves this cycle
  assign fetch_fire = fetch_en && (!q_full || pop);

  // Out-of-range fetches carry a zero instruction and the fault flag
  assign fetch_word = pc_in_range ? mem[pc[MIDX_W-1:0]] : '0;
  assign push_entry = {~pc_in_range, pc, fetch_word};

  // FSM state register
  always_ff @(posedge Clk) begin
    if (!Reset) cur_state <= ST_IDLE;
    else        cur_state <= nxt_state;
  end

  // FSM next-state logic
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      ST_IDLE:  if (start) nxt_state = ST_RUN;
      ST_RUN:   if (fetch_fire && !pc_in_range) nxt_state = ST_FAULT;
      ST_FAULT: if (redirect_valid) nxt_state = ST_RUN;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  // FSM outputs: fetch is allowed only in RUN, and yields to program load and redirect
  always_comb begin
    fetch_en = 1'b0;
    state    = cur_state;
    if (cur_state == ST_RUN && !prog_we && !redirect_valid) fetch_en = 1'b1;
  end

  // PC: redirect in any state, otherwise advance on each in-range fetch; a fault holds it
  always_ff @(posedge Clk) begin
    if (!Reset)                       pc <= PC_RESET;
    else if (redirect_valid)          pc <= redirect_pc;
    else if (fetch_fire && pc_in_range) pc <= pc + PC_ONE;
  end

  // Program load; the array has no reset so a loaded program survives Reset
  always_ff @(posedge Clk) begin
    if (Reset && prog_we && prog_in_range) mem[prog_addr[MIDX_W-1:0]] <= prog_data;
  end

  ifu_fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (fetch_fire),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  assign out_instr   = q_head[INSTR_W-1:0];
  assign out_pc      = q_head[INSTR_W +: ADDR_W];
  assign out_fault   = q_head[ENTRY_W-1];
  // Gated so an empty queue drives an all-zero bundle rather than 0+1
  assign out_pc_next = out_valid ? (out_pc + PC_ONE) : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a scoreboard checks every accepted head against
// the expected stream, a vector table covers back-pressure, and short
// hand-written sequences cover redirect, fault, wrap and mid-stream reset.
module tb_instr_fetch_unit;

  logic       Clk;
  logic       Reset;

  // Instance A: ADDR_W=8, MEM_DEPTH=8, QUEUE_DEPTH=2
  logic       start, prog_we, redirect_valid, out_ready;
  logic [7:0] prog_addr, prog_data, redirect_pc;
  logic       out_valid, out_fault;
  logic [7:0] out_instr, out_pc, out_pc_next;
  logic [1:0] state;

  // Instance B: ADDR_W=3, MEM_DEPTH=8, QUEUE_DEPTH=1 (PC wrap)
  logic       start_b, prog_we_b, redirect_valid_b, out_ready_b;
  logic [2:0] prog_addr_b, redirect_pc_b;
  logic [7:0] prog_data_b;
  logic       out_valid_b, out_fault_b;
  logic [7:0] out_instr_b;
  logic [2:0] out_pc_b, out_pc_next_b;
  logic [1:0] state_b;

  instr_fetch_unit #(
    .ADDR_W(8), .INSTR_W(8), .MEM_DEPTH(8), .QUEUE_DEPTH(2), .RESET_PC(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_fault(out_fault),
    .state(state)
  );

  instr_fetch_unit #(
    .ADDR_W(3), .INSTR_W(8), .MEM_DEPTH(8), .QUEUE_DEPTH(1), .RESET_PC(0)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .start(start_b), .prog_we(prog_we_b),
    .prog_addr(prog_addr_b), .prog_data(prog_data_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
    .out_pc(out_pc_b), .out_pc_next(out_pc_next_b), .out_fault(out_fault_b),
    .state(state_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb[$];
  logic        mon_en = 1'b0;

  logic [7:0] prog  [8];
  logic [7:0] progb [8];

  typedef struct {
    logic       ready;
    logic       valid;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] nxt;
    logic [1:0] st;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic f, input logic [7:0] i,
                                      input logic [7:0] p, input logic [7:0] n);
    return {7'b0, f, i, p, n};
  endfunction

  function automatic logic [31:0] head_a();
    return {7'b0, out_fault, out_instr, out_pc, out_pc_next};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic push_program_stream();
    for (int i = 0; i < 8; i++) sb.push_back(ent(1'b0, prog[i], 8'(i), 8'(i + 1)));
    sb.push_back(ent(1'b1, 8'h00, 8'd8, 8'd9));
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expectation
  always @(negedge Clk) begin
    if (mon_en && Reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h expected none", head_a());
      end else begin
        check("stream", head_a(), sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int n;
    prog  = '{8'h33, 8'h71, 8'h1C, 8'hC1, 8'h5A, 8'hA5, 8'h6E, 8'hE6};
    progb = '{8'h5C, 8'h0F, 8'hE2, 8'h97, 8'h40, 8'hB6, 8'h21, 8'hD8};

    // ready, valid, instr, pc, next, state: head holds under back-pressure, then drains in order
    vecs[0] = '{1'b0, 1'b0, 8'h00, 8'd0, 8'd0, 2'd1};
    vecs[1] = '{1'b0, 1'b1, 8'h33, 8'd0, 8'd1, 2'd1};
    vecs[2] = '{1'b0, 1'b1, 8'h33, 8'd0, 8'd1, 2'd1};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 8'd0, 8'd1, 2'd1};
    vecs[4] = '{1'b0, 1'b1, 8'h33, 8'd0, 8'd1, 2'd1};
    vecs[5] = '{1'b0, 1'b1, 8'h33, 8'd0, 8'd1, 2'd1};
    vecs[6] = '{1'b1, 1'b1, 8'h33, 8'd0, 8'd1, 2'd1};
    vecs[7] = '{1'b1, 1'b1, 8'h71, 8'd1, 8'd2, 2'd1};
    vecs[8] = '{1'b1, 1'b1, 8'h1C, 8'd2, 8'd3, 2'd1};
    vecs[9] = '{1'b0, 1'b1, 8'hC1, 8'd3, 8'd4, 2'd1};

    Reset = 1'b0;
    start = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    start_b = 0; prog_we_b = 0; prog_addr_b = 0; prog_data_b = 0;
    redirect_valid_b = 0; redirect_pc_b = 0; out_ready_b = 0;

    // Reset state
    repeat (3) tick();
    @(negedge Clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", head_a(), 32'd0);
    check("rst_state", 32'(state), 32'd0);

    // Program load, plus an out-of-range write that must not alias onto word 0
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prog_we = 1; prog_addr = 8'(i); prog_data = prog[i];
      tick();
    end
    prog_addr = 8'd8; prog_data = 8'hFF;
    tick();
    prog_we = 0;

    // Straight-line run to the end of memory and into FAULT
    push_program_stream();
    mon_en = 1; out_ready = 1; start = 1;
    tick();
    start = 0;
    @(negedge Clk);
    check("start_state", 32'(state), 32'd1);
    check("first_latency", 32'(out_valid), 32'd0);
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge Clk);
      if (out_valid) nv++;
    end
    check("no_bubbles", nv, 4);
    drain("drain_run", 30);
    @(negedge Clk);
    check("fault_state", 32'(state), 32'd2);
    nv = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge Clk);
      if (out_valid) nv++;
    end
    check("fault_quiet", nv, 0);

    // Redirect out of FAULT, then back-pressure table
    tick();
    mon_en = 0; out_ready = 0;
    redirect_valid = 1; redirect_pc = 8'd0;
    tick();
    redirect_valid = 0;
    @(negedge Clk);
    check("redir_state", 32'(state), 32'd1);
    check("redir_empty", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      out_ready = vecs[i].ready;
      check($sformatf("vec%0d", i),
            {5'b0, out_valid, state, out_instr, out_pc, out_pc_next},
            {5'b0, vecs[i].valid, vecs[i].st, vecs[i].instr, vecs[i].pc, vecs[i].nxt});
      tick();
      @(negedge Clk);
    end

    // Redirect to 6 in the same cycle the pc1 head is consumed
    tick();
    out_ready = 0;
    redirect_valid = 1; redirect_pc = 8'd0;
    tick();
    redirect_valid = 0;
    tick();
    tick();
    sb.push_back(ent(1'b0, prog[0], 8'd0, 8'd1));
    sb.push_back(ent(1'b0, prog[1], 8'd1, 8'd2));
    sb.push_back(ent(1'b0, prog[6], 8'd6, 8'd7));
    sb.push_back(ent(1'b0, prog[7], 8'd7, 8'd8));
    sb.push_back(ent(1'b1, 8'h00, 8'd8, 8'd9));
    mon_en = 1; out_ready = 1;
    tick();
    redirect_valid = 1; redirect_pc = 8'd6;
    tick();
    redirect_valid = 0;
    @(negedge Clk);
    check("redir_gap", 32'(out_valid), 32'd0);
    tick();
    @(negedge Clk);
    check("redir_rise", 32'(out_valid), 32'd1);
    drain("drain_redir", 20);
    @(negedge Clk);
    check("redir_fault_state", 32'(state), 32'd2);

    // Reset mid-stream with the queue full, then replay the program
    tick();
    mon_en = 0; out_ready = 0;
    redirect_valid = 1; redirect_pc = 8'd0;
    tick();
    redirect_valid = 0;
    tick();
    tick();
    @(negedge Clk);
    check("pre_reset_head", {31'b0, out_valid}, 32'd1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    @(negedge Clk);
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_data", head_a(), 32'd0);
    tick();
    push_program_stream();
    mon_en = 1; out_ready = 1; start = 1;
    tick();
    start = 0;
    drain("drain_replay", 40);
    @(negedge Clk);
    check("replay_fault_state", 32'(state), 32'd2);
    tick();
    mon_en = 0; out_ready = 0;

    // 3-bit PC wraps 7 -> 0, with pc_next of 7 reading 0
    for (int i = 0; i < 8; i++) begin
      prog_we_b = 1; prog_addr_b = 3'(i); prog_data_b = progb[i];
      tick();
    end
    prog_we_b = 0;
    out_ready_b = 1; start_b = 1;
    tick();
    start_b = 0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      @(negedge Clk);
      while (!out_valid_b && n < 8) begin
        @(negedge Clk);
        n++;
      end
      check($sformatf("wrap%0d", k),
            {16'b0, out_valid_b, out_fault_b, out_instr_b, out_pc_b, out_pc_next_b},
            {16'b0, 1'b1, 1'b0, progb[k % 8], 3'(k % 8), 3'((k + 1) % 8)});
    end
    check("wrap_state", 32'(state_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
